// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Sequenced control unit for an RV32I core. Each instruction is
//            stepped through fetch / decode / execute / memory / writeback
//            over a shared ALU and a single ready-handshaked memory port.
//            Optional RV32M dispatch to an external iterative mul/div unit,
//            a memory-wait watchdog and sticky trap reporting.
// Ports    : clk, reset (sync, active-high)
//            opcode/funct3/funct7 : instruction fields from the IR
//            mem_ready, branch_taken, muldiv_done : datapath/memory status
//            mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
//            ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, BranchControl,
//            LoadControl, StoreControl : datapath controls
//            muldiv_start, instret : one-cycle pulses
//            trap, trap_cause : sticky fault status (01 illegal, 10 timeout)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int M_EXT       = 0,
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    input  logic       branch_taken,
    input  logic       muldiv_done,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [2:0] BranchControl,
    output logic [2:0] LoadControl,
    output logic [2:0] StoreControl,
    output logic       muldiv_start,
    output logic       instret,
    output logic       trap,
    output logic [1:0] trap_cause
);

    localparam logic [4:0] c_FETCH    = 5'd0;
    localparam logic [4:0] c_DECODE   = 5'd1;
    localparam logic [4:0] c_MEMADR   = 5'd2;
    localparam logic [4:0] c_MEMREAD  = 5'd3;
    localparam logic [4:0] c_MEMWB    = 5'd4;
    localparam logic [4:0] c_MEMWRITE = 5'd5;
    localparam logic [4:0] c_EXECR    = 5'd6;
    localparam logic [4:0] c_EXECI    = 5'd7;
    localparam logic [4:0] c_LUI      = 5'd8;
    localparam logic [4:0] c_ALUWB    = 5'd9;
    localparam logic [4:0] c_BRANCH   = 5'd10;
    localparam logic [4:0] c_JAL      = 5'd11;
    localparam logic [4:0] c_JALR     = 5'd12;
    localparam logic [4:0] c_JALR2    = 5'd13;
    localparam logic [4:0] c_MULDIV   = 5'd14;
    localparam logic [4:0] c_MULWB    = 5'd15;
    localparam logic [4:0] c_TRAP     = 5'd16;

    localparam logic [6:0] c_OP_LOAD   = 7'd3;
    localparam logic [6:0] c_OP_STORE  = 7'd35;
    localparam logic [6:0] c_OP_R      = 7'd51;
    localparam logic [6:0] c_OP_I      = 7'd19;
    localparam logic [6:0] c_OP_AUIPC  = 7'd23;
    localparam logic [6:0] c_OP_LUI    = 7'd55;
    localparam logic [6:0] c_OP_BRANCH = 7'd99;
    localparam logic [6:0] c_OP_JAL    = 7'd111;
    localparam logic [6:0] c_OP_JALR   = 7'd103;

    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b10;

    localparam logic            c_WD_EN   = (MEM_TIMEOUT > 0);
    // Count value at which one more empty wait cycle means timeout.
    localparam logic [TO_W-1:0] c_WD_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [4:0]      r_state;
    logic [4:0]      w_state_next;
    logic [1:0]      r_trap_cause;
    logic [1:0]      w_trap_cause_next;
    logic            r_md_busy;
    logic [TO_W-1:0] r_wd;
    logic            w_waiting;
    logic            w_wd_hit;

    // A memory wait cycle: request outstanding and not yet acknowledged.
    assign w_waiting = ((r_state == c_FETCH) || (r_state == c_MEMREAD) ||
                        (r_state == c_MEMWRITE)) && !mem_ready;

    // The counter is zero outside wait cycles, so every entry into a memory
    // state starts from zero; mem_ready on the final cycle pre-empts the trap.
    assign w_wd_hit = c_WD_EN && w_waiting && (r_wd == c_WD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_FETCH;
            r_trap_cause <= 2'b00;
            r_md_busy    <= 1'b0;
            r_wd         <= '0;
        end else begin
            r_state      <= w_state_next;
            r_trap_cause <= w_trap_cause_next;
            // Set from the second MULDIV cycle on so muldiv_start is a single pulse.
            r_md_busy    <= (r_state == c_MULDIV);
            if (c_WD_EN && w_waiting) begin
                r_wd <= r_wd + 1'b1;
            end else begin
                r_wd <= '0;
            end
        end
    end

    always_comb begin
        ImmSrc = 3'b000;
        case (opcode)
            c_OP_STORE:            ImmSrc = 3'b001;
            c_OP_BRANCH:           ImmSrc = 3'b010;
            c_OP_JAL:              ImmSrc = 3'b011;
            c_OP_LUI, c_OP_AUIPC:  ImmSrc = 3'b100;
            default:               ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        w_state_next      = r_state;
        w_trap_cause_next = r_trap_cause;
        mem_req           = 1'b0;
        AdrSrc            = 1'b0;
        MemWrite          = 1'b0;
        IRWrite           = 1'b0;
        PCWrite           = 1'b0;
        RegWrite          = 1'b0;
        ALUSrcA           = 2'b00;
        ALUSrcB           = 2'b00;
        ALUOp             = 4'b0000;
        ResultSrc         = 2'b00;
        BranchControl     = 3'b000;
        LoadControl       = 3'b000;
        StoreControl      = 3'b000;
        muldiv_start      = 1'b0;
        instret           = 1'b0;

        // Everything stays deasserted in the reset cycle.
        if (!reset) begin
            case (r_state)
                c_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IRWrite      = 1'b1;
                        PCWrite      = 1'b1;
                        ALUSrcB      = 2'b10;
                        ResultSrc    = 2'b10;
                        w_state_next = c_DECODE;
                    end else if (w_wd_hit) begin
                        w_state_next      = c_TRAP;
                        w_trap_cause_next = c_CAUSE_TIMEOUT;
                    end
                end
                c_DECODE: begin
                    // Speculative OldPC+imm for branch/JAL/AUIPC targets.
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    case (opcode)
                        c_OP_LOAD, c_OP_STORE: w_state_next = c_MEMADR;
                        c_OP_R:                w_state_next = c_EXECR;
                        c_OP_I:                w_state_next = c_EXECI;
                        c_OP_AUIPC:            w_state_next = c_ALUWB;
                        c_OP_LUI:              w_state_next = c_LUI;
                        c_OP_BRANCH:           w_state_next = c_BRANCH;
                        c_OP_JAL:              w_state_next = c_JAL;
                        c_OP_JALR:             w_state_next = c_JALR;
                        default: begin
                            w_state_next      = c_TRAP;
                            w_trap_cause_next = c_CAUSE_ILLEGAL;
                        end
                    endcase
                end
                c_MEMADR: begin
                    ALUSrcA      = 2'b10;
                    ALUSrcB      = 2'b01;
                    w_state_next = (opcode == c_OP_LOAD) ? c_MEMREAD : c_MEMWRITE;
                end
                c_MEMREAD: begin
                    mem_req     = 1'b1;
                    AdrSrc      = 1'b1;
                    LoadControl = funct3;
                    if (mem_ready) begin
                        w_state_next = c_MEMWB;
                    end else if (w_wd_hit) begin
                        w_state_next      = c_TRAP;
                        w_trap_cause_next = c_CAUSE_TIMEOUT;
                    end
                end
                c_MEMWB: begin
                    ResultSrc    = 2'b01;
                    RegWrite     = 1'b1;
                    LoadControl  = funct3;
                    instret      = 1'b1;
                    w_state_next = c_FETCH;
                end
                c_MEMWRITE: begin
                    mem_req      = 1'b1;
                    AdrSrc       = 1'b1;
                    MemWrite     = 1'b1;
                    StoreControl = funct3;
                    if (mem_ready) begin
                        instret      = 1'b1;
                        w_state_next = c_FETCH;
                    end else if (w_wd_hit) begin
                        w_state_next      = c_TRAP;
                        w_trap_cause_next = c_CAUSE_TIMEOUT;
                    end
                end
                c_EXECR: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = {funct7[5], funct3};
                    if (funct7 == 7'b0000001) begin
                        if (M_EXT != 0) begin
                            w_state_next = c_MULDIV;
                        end else begin
                            w_state_next      = c_TRAP;
                            w_trap_cause_next = c_CAUSE_ILLEGAL;
                        end
                    end else begin
                        w_state_next = c_ALUWB;
                    end
                end
                c_EXECI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    // Only the shift-right group uses funct7[5] (SRLI/SRAI).
                    ALUOp        = (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
                    w_state_next = c_ALUWB;
                end
                c_LUI: begin
                    ALUSrcB      = 2'b01;
                    ALUOp        = 4'b1111;
                    w_state_next = c_ALUWB;
                end
                c_ALUWB: begin
                    RegWrite     = 1'b1;
                    instret      = 1'b1;
                    w_state_next = c_FETCH;
                end
                c_BRANCH: begin
                    ALUSrcA       = 2'b10;
                    BranchControl = funct3;
                    PCWrite       = branch_taken;
                    instret       = 1'b1;
                    w_state_next  = c_FETCH;
                end
                c_JAL, c_JALR2: begin
                    // PC <= target in ALUOut while the link OldPC+4 is formed.
                    PCWrite      = 1'b1;
                    ALUSrcA      = 2'b01;
                    ALUSrcB      = 2'b10;
                    w_state_next = c_ALUWB;
                end
                c_JALR: begin
                    ALUSrcA      = 2'b10;
                    ALUSrcB      = 2'b01;
                    w_state_next = c_JALR2;
                end
                c_MULDIV: begin
                    muldiv_start = !r_md_busy;
                    if (muldiv_done) begin
                        w_state_next = c_MULWB;
                    end
                end
                c_MULWB: begin
                    ResultSrc    = 2'b11;
                    RegWrite     = 1'b1;
                    instret      = 1'b1;
                    w_state_next = c_FETCH;
                end
                c_TRAP: begin
                    w_state_next = c_TRAP;
                end
                default: begin
                    w_state_next = c_FETCH;
                end
            endcase
        end
    end

    assign trap       = (r_state == c_TRAP);
    assign trap_cause = r_trap_cause;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Scoreboard bench for multicycle_control. Instance A runs with
//            RV32M and a 4-cycle memory watchdog, instance B with neither.
//            The stimulus side expands each instruction into its expected
//            per-cycle control vector and queues it; a monitor pops and
//            compares one vector per clock for the instance under test.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    typedef struct packed {
        logic       mem_req;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [3:0] op;
        logic [1:0] rs;
        logic [2:0] imm;
        logic [2:0] bc;
        logic [2:0] lc;
        logic [2:0] sc;
        logic       ms;
        logic       ir;
        logic       trap;
        logic [1:0] cause;
    } outv_t;

    typedef struct packed {
        logic  sel;
        outv_t v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       mem_ready, branch_taken, muldiv_done;

    always #5 clk = ~clk;

    logic       a_mem_req, a_adr, a_mw, a_irw, a_pcw, a_rw, a_ms, a_ir, a_trap;
    logic [1:0] a_sa, a_sb, a_rs, a_cause;
    logic [3:0] a_op;
    logic [2:0] a_imm, a_bc, a_lc, a_sc;
    logic       b_mem_req, b_adr, b_mw, b_irw, b_pcw, b_rw, b_ms, b_ir, b_trap;
    logic [1:0] b_sa, b_sb, b_rs, b_cause;
    logic [3:0] b_op;
    logic [2:0] b_imm, b_bc, b_lc, b_sc;

    multicycle_control #(.M_EXT(1), .MEM_TIMEOUT(4), .TO_W(8)) u_dut_a (
        .clk(clk), .reset(rst_a), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .branch_taken(branch_taken), .muldiv_done(muldiv_done),
        .mem_req(a_mem_req), .AdrSrc(a_adr), .MemWrite(a_mw), .IRWrite(a_irw),
        .PCWrite(a_pcw), .RegWrite(a_rw), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALUOp(a_op),
        .ResultSrc(a_rs), .ImmSrc(a_imm), .BranchControl(a_bc), .LoadControl(a_lc),
        .StoreControl(a_sc), .muldiv_start(a_ms), .instret(a_ir), .trap(a_trap),
        .trap_cause(a_cause)
    );

    multicycle_control #(.M_EXT(0), .MEM_TIMEOUT(0), .TO_W(8)) u_dut_b (
        .clk(clk), .reset(rst_b), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .branch_taken(branch_taken), .muldiv_done(muldiv_done),
        .mem_req(b_mem_req), .AdrSrc(b_adr), .MemWrite(b_mw), .IRWrite(b_irw),
        .PCWrite(b_pcw), .RegWrite(b_rw), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALUOp(b_op),
        .ResultSrc(b_rs), .ImmSrc(b_imm), .BranchControl(b_bc), .LoadControl(b_lc),
        .StoreControl(b_sc), .muldiv_start(b_ms), .instret(b_ir), .trap(b_trap),
        .trap_cause(b_cause)
    );

    outv_t act_a, act_b;
    assign act_a = {a_mem_req, a_adr, a_mw, a_irw, a_pcw, a_rw, a_sa, a_sb, a_op, a_rs,
                    a_imm, a_bc, a_lc, a_sc, a_ms, a_ir, a_trap, a_cause};
    assign act_b = {b_mem_req, b_adr, b_mw, b_irw, b_pcw, b_rw, b_sa, b_sb, b_op, b_rs,
                    b_imm, b_bc, b_lc, b_sc, b_ms, b_ir, b_trap, b_cause};

    // Scoreboard and reference-model state
    exp_t       q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic       cur_sel;
    int         m_ext;
    int         t_out;
    logic       m_trapped;
    logic [1:0] m_cause;
    logic [6:0] ops[0:9];

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'd35:        return 3'b001;
            7'd99:        return 3'b010;
            7'd111:       return 3'b011;
            7'd55, 7'd23: return 3'b100;
            default:      return 3'b000;
        endcase
    endfunction

    function automatic outv_t base();
        outv_t v;
        v       = '0;
        v.imm   = imm_of(opcode);
        v.trap  = m_trapped;
        v.cause = m_cause;
        return v;
    endfunction

    // One clock: apply inputs, queue the expected vector, advance.
    task automatic step(input logic rdy, input logic tk, input logic dn, input outv_t e);
        exp_t x;
        mem_ready    = rdy;
        branch_taken = tk;
        muldiv_done  = dn;
        x.sel = cur_sel;
        x.v   = e;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        if (cur_sel) rst_b = 1'b1; else rst_a = 1'b1;
        step(rb(), rb(), rb(), base());
        if (cur_sel) rst_b = 1'b0; else rst_a = 1'b0;
        m_trapped = 1'b0;
        m_cause   = 2'b00;
    endtask

    task automatic trap_tail(input logic [1:0] cause);
        outv_t e;
        m_trapped = 1'b1;
        m_cause   = cause;
        e = base();
        repeat ($urandom_range(1, 3)) step(rb(), rb(), rb(), e);
        do_reset();
    endtask

    // w cycles without mem_ready; with a watchdog, T empty cycles is fatal.
    task automatic mem_wait(input int w, input outv_t e, output logic trapped);
        trapped = 1'b0;
        if (t_out > 0 && w >= t_out) begin
            repeat (t_out) step(1'b0, rb(), rb(), e);
            trap_tail(2'b10);
            trapped = 1'b1;
        end else begin
            repeat (w) step(1'b0, rb(), rb(), e);
        end
    endtask

    task automatic writeback_alu();
        outv_t e;
        e = base(); e.rw = 1'b1; e.ir = 1'b1;
        step(rb(), rb(), rb(), e);
    endtask

    task automatic jal_cycle();
        outv_t e;
        e = base(); e.pcw = 1'b1; e.sa = 2'b01; e.sb = 2'b10;
        step(rb(), rb(), rb(), e);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int fw, input int mw, input logic tk, input int lat);
        outv_t e;
        logic  tr;
        opcode = op; funct3 = f3; funct7 = f7;
        // fetch
        e = base(); e.mem_req = 1'b1;
        mem_wait(fw, e, tr);
        if (tr) return;
        e.irw = 1'b1; e.pcw = 1'b1; e.sb = 2'b10; e.rs = 2'b10;
        step(1'b1, rb(), rb(), e);
        // decode
        e = base(); e.sa = 2'b01; e.sb = 2'b01;
        step(rb(), rb(), rb(), e);
        case (op)
            7'd3, 7'd35: begin
                e = base(); e.sa = 2'b10; e.sb = 2'b01;
                step(rb(), rb(), rb(), e);
                e = base(); e.mem_req = 1'b1; e.adr = 1'b1;
                if (op == 7'd3) e.lc = f3; else begin e.mw = 1'b1; e.sc = f3; end
                mem_wait(mw, e, tr);
                if (tr) return;
                if (op == 7'd35) e.ir = 1'b1;
                step(1'b1, rb(), rb(), e);
                if (op == 7'd3) begin
                    e = base(); e.rs = 2'b01; e.rw = 1'b1; e.lc = f3; e.ir = 1'b1;
                    step(rb(), rb(), rb(), e);
                end
            end
            7'd51: begin
                e = base(); e.sa = 2'b10; e.op = {f7[5], f3};
                step(rb(), rb(), rb(), e);
                if (f7 == 7'b0000001) begin
                    if (m_ext == 0) begin
                        trap_tail(2'b01);
                        return;
                    end
                    for (int i = 0; i <= lat; i++) begin
                        e = base(); e.ms = (i == 0);
                        step(rb(), rb(), (i == lat), e);
                    end
                    e = base(); e.rs = 2'b11; e.rw = 1'b1; e.ir = 1'b1;
                    step(rb(), rb(), rb(), e);
                end else begin
                    writeback_alu();
                end
            end
            7'd19: begin
                e = base(); e.sa = 2'b10; e.sb = 2'b01;
                e.op = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
                step(rb(), rb(), rb(), e);
                writeback_alu();
            end
            7'd23: writeback_alu();
            7'd55: begin
                e = base(); e.sb = 2'b01; e.op = 4'hF;
                step(rb(), rb(), rb(), e);
                writeback_alu();
            end
            7'd99: begin
                e = base(); e.sa = 2'b10; e.bc = f3; e.pcw = tk; e.ir = 1'b1;
                step(rb(), tk, rb(), e);
            end
            7'd111: begin
                jal_cycle();
                writeback_alu();
            end
            7'd103: begin
                e = base(); e.sa = 2'b10; e.sb = 2'b01;
                step(rb(), rb(), rb(), e);
                jal_cycle();
                writeback_alu();
            end
            default: trap_tail(2'b01);
        endcase
    endtask

    function automatic int rwait();
        if (t_out > 0)
            return ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 5));
        return int'($urandom_range(0, 6));
    endfunction

    task automatic rand_instr();
        logic [6:0] op, f7;
        int         idx;
        idx = int'($urandom_range(0, 9));
        op  = ops[idx];
        if (idx == 9) op = rb() ? 7'h0F : 7'h7F;
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom_range(0, 127));
        endcase
        run_instr(op, 3'($urandom_range(0, 7)), f7, rwait(), rwait(), rb(),
                  int'($urandom_range(0, 5)));
    endtask

    // Monitor: one expected vector per clock for the selected instance.
    always @(negedge clk) begin
        exp_t  x;
        outv_t a;
        if (q.size() > 0) begin
            x = q.pop_front();
            a = x.sel ? act_b : act_a;
            n_chk++;
            if (a === x.v) n_pass++;
            else $display("FAIL ctrl_vec #%0d dut_%s: got=%h want=%h", n_chk,
                          x.sel ? "B" : "A", a, x.v);
        end
    end

    initial begin
        ops[0] = 7'd3;  ops[1] = 7'd35;  ops[2] = 7'd51;  ops[3] = 7'd19;  ops[4] = 7'd23;
        ops[5] = 7'd55; ops[6] = 7'd99;  ops[7] = 7'd111; ops[8] = 7'd103; ops[9] = 7'h7F;
        rst_a = 1'b1; rst_b = 1'b1;
        opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        mem_ready = 1'b0; branch_taken = 1'b0; muldiv_done = 1'b0;
        cur_sel = 1'b0; m_ext = 1; t_out = 4;
        m_trapped = 1'b0; m_cause = 2'b00;
        @(posedge clk);
        #1;
        // Instance A: RV32M on, watchdog 4
        do_reset();
        run_instr(7'd51, 3'd0, 7'h20, 0, 0, 1'b0, 0);   // sub
        run_instr(7'd3,  3'd2, 7'h00, 0, 3, 1'b0, 0);   // lw, 3 wait cycles
        run_instr(7'd99, 3'd0, 7'h00, 0, 0, 1'b1, 0);   // beq taken
        run_instr(7'd99, 3'd0, 7'h00, 0, 0, 1'b0, 0);   // beq not taken
        run_instr(7'd103, 3'd0, 7'h00, 0, 0, 1'b0, 0);  // jalr
        run_instr(7'd51, 3'd0, 7'h01, 0, 0, 1'b0, 4);   // mul, done on 5th cycle
        run_instr(7'd35, 3'd2, 7'h00, 0, 3, 1'b0, 0);   // sw, ready on 4th cycle
        run_instr(7'd19, 3'd0, 7'h00, 4, 0, 1'b0, 0);   // fetch timeout
        run_instr(7'd19, 3'd5, 7'h20, 3, 0, 1'b0, 0);   // ready on 4th cycle
        run_instr(7'd3,  3'd0, 7'h00, 0, 4, 1'b0, 0);   // load timeout
        run_instr(7'h0F, 3'd0, 7'h00, 0, 0, 1'b0, 0);   // illegal opcode
        repeat (250) rand_instr();
        // Instance B: no RV32M, no watchdog
        rst_a = 1'b1;
        cur_sel = 1'b1; m_ext = 0; t_out = 0;
        m_trapped = 1'b0; m_cause = 2'b00;
        do_reset();
        run_instr(7'd19, 3'd1, 7'h00, 9, 0, 1'b0, 0);   // long fetch wait, no trap
        run_instr(7'd51, 3'd0, 7'h01, 0, 0, 1'b0, 0);   // mul illegal -> trap 01
        repeat (100) rand_instr();
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got=%0d pending want=0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
